// File: rtl/mindfocus_pkg.sv
// State codes and default timing shared by the mindfocus control blocks.
// The codes also drive db_estado for the hexa7seg debug display.
package mindfocus_pkg;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PREPARA = 4'd1,
        ACESO   = 4'd2,
        APAGADO = 4'd3,
        PROXIMO = 4'd4,
        FIM     = 4'd5
    } estado_t;

    localparam int T_ACESO_PADRAO   = 500;
    localparam int T_APAGADO_PADRAO = 250;
    localparam int TMR_W_PADRAO     = 16;

endpackage

// File: rtl/contador_tmr.sv
// Up-counter for LED on/off pacing. It holds at the terminal value instead of
// wrapping, so fim stays asserted until the counter is cleared.
module contador_tmr #(
    parameter int TMR_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             zera,
    input  logic             conta,
    input  logic [TMR_W-1:0] terminal,
    output logic             fim
);

    logic [TMR_W-1:0] valor_q, valor_d;

    assign fim = (valor_q == terminal);

    always_comb begin
        valor_d = valor_q;
        if (zera) begin
            valor_d = '0;
        end else if (conta && !fim) begin
            valor_d = valor_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

endmodule

// File: rtl/controle_exibicao_sequencia.sv
// Plays the stored sequence back on the LEDs: one lit window and one dark gap
// per item, stepping the datapath address until it reaches the round's limit.
module controle_exibicao_sequencia
    import mindfocus_pkg::*;
#(
    parameter int T_ACESO   = T_ACESO_PADRAO,
    parameter int T_APAGADO = T_APAGADO_PADRAO,
    parameter int TMR_W     = TMR_W_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       cancelar,
    input  logic       enderecoIgualLimite,
    output logic       zeraE,
    output logic       contaE,
    output logic       mostra_leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam logic [TMR_W-1:0] TERM_ACESO   = TMR_W'(T_ACESO - 1);
    localparam logic [TMR_W-1:0] TERM_APAGADO = TMR_W'(T_APAGADO - 1);

    estado_t          estado_q, estado_d;
    logic             tmr_zera, tmr_conta, tmr_fim;
    logic [TMR_W-1:0] tmr_terminal;

    // A single timer serves both phases; only its terminal value changes.
    assign tmr_terminal = (estado_q == APAGADO) ? TERM_APAGADO : TERM_ACESO;

    contador_tmr #(
        .TMR_W(TMR_W)
    ) u_tmr (
        .clock   (clock),
        .reset   (reset),
        .zera    (tmr_zera),
        .conta   (tmr_conta),
        .terminal(tmr_terminal),
        .fim     (tmr_fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        tmr_zera  = 1'b0;
        tmr_conta = 1'b0;
        case (estado_q)
            INICIAL: begin
                tmr_zera = 1'b1;
                if (iniciar) estado_d = PREPARA;
            end
            PREPARA: begin
                tmr_zera = 1'b1;
                estado_d = ACESO;
            end
            ACESO: begin
                tmr_conta = 1'b1;
                if (tmr_fim) begin
                    tmr_zera = 1'b1;
                    estado_d = APAGADO;
                end
            end
            APAGADO: begin
                tmr_conta = 1'b1;
                if (tmr_fim) begin
                    tmr_zera = 1'b1;
                    estado_d = enderecoIgualLimite ? FIM : PROXIMO;
                end
            end
            PROXIMO: estado_d = ACESO;
            FIM:     estado_d = INICIAL;
            default: begin
                tmr_zera = 1'b1;
                estado_d = INICIAL;
            end
        endcase
        // Abort overrides any terminal-count transition taken above.
        if (cancelar && (estado_q != INICIAL)) begin
            estado_d  = INICIAL;
            tmr_zera  = 1'b1;
            tmr_conta = 1'b0;
        end
    end

    always_comb begin
        zeraE       = (estado_q == PREPARA);
        contaE      = (estado_q == PROXIMO);
        mostra_leds = (estado_q == ACESO);
        pronto      = (estado_q == FIM);
        ocupado     = (estado_q != INICIAL);
        db_estado   = estado_q;
    end

endmodule

// File: tb/tb_controle_exibicao_sequencia.sv
// Randomised bench for the LED playback sequencer, checked cycle by cycle
// against a timeline model derived from the item count.
module tb_controle_exibicao_sequencia;

    localparam int TA = 3;
    localparam int TP = 2;
    localparam int PER_ITEM = TA + TP + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       cancelar = 1'b0;
    logic       enderecoIgualLimite;
    logic       zeraE, contaE, mostra_leds, ocupado, pronto;
    logic [3:0] db_estado;

    logic [7:0] addr = 8'd0;
    logic [7:0] limite = 8'd0;
    logic       flag_tie = 1'b0;

    int checks = 0;
    int failures = 0;

    controle_exibicao_sequencia #(
        .T_ACESO  (TA),
        .T_APAGADO(TP),
        .TMR_W    (4)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .iniciar            (iniciar),
        .cancelar           (cancelar),
        .enderecoIgualLimite(enderecoIgualLimite),
        .zeraE              (zeraE),
        .contaE             (contaE),
        .mostra_leds        (mostra_leds),
        .ocupado            (ocupado),
        .pronto             (pronto),
        .db_estado          (db_estado)
    );

    always #5 clock = ~clock;

    // Stand-in for the datapath address counter and its limit comparator.
    always @(posedge clock) begin
        if (zeraE) addr <= 8'd0;
        else if (contaE) addr <= addr + 8'd1;
    end
    assign enderecoIgualLimite = flag_tie | (addr == limite);

    function automatic logic [8:0] observed();
        return {zeraE, contaE, mostra_leds, ocupado, pronto, db_estado};
    endfunction

    // Expected {zeraE,contaE,mostra_leds,ocupado,pronto,db_estado} in cycle c
    // after the edge that sampled iniciar, for a playback of n items.
    function automatic logic [8:0] modelo(input int c, input int n);
        int p;
        if (c == 1) return {5'b10010, 4'd1};
        if (c >= 2 && c <= PER_ITEM * n) begin
            p = (c - 2) % PER_ITEM;
            if (p < TA)      return {5'b00110, 4'd2};
            if (p < TA + TP) return {5'b00010, 4'd3};
            return {5'b01010, 4'd4};
        end
        if (c == PER_ITEM * n + 1) return {5'b00011, 4'd5};
        return 9'd0;
    endfunction

    // One playback (or reps back-to-back with iniciar held), optionally with a
    // cancel in cycle cancel_c and a spurious iniciar pulse in cycle ign_c.
    task automatic play(input string nome, input int n, input int cancel_c,
                        input int ign_c, input int reps);
        int len, total, rc;
        logic [8:0] esp, obs;
        len   = PER_ITEM * n + 2;
        total = reps * len + 2;
        limite = 8'(n - 1);
        @(negedge clock);
        iniciar = 1'b1;
        for (int c = 1; c <= total; c++) begin
            @(negedge clock);
            rc = (c <= reps * len) ? ((c - 1) % len) + 1 : len;
            esp = modelo(rc, n);
            if (cancel_c > 0 && c > cancel_c) esp = 9'd0;
            obs = observed();
            checks++;
            if (obs !== esp) begin
                failures++;
                $display("FAIL %s n=%0d cycle=%0d got=%b want=%b", nome, n, c, obs, esp);
            end
            iniciar  = (c < (reps - 1) * len + 1) || (c == ign_c);
            cancelar = (c == cancel_c);
        end
        iniciar  = 1'b0;
        cancelar = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        iniciar = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if (observed() !== 9'd0) begin
                failures++;
                $display("FAIL reset_outputs got=%b want=%b", observed(), 9'd0);
            end
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (observed() !== {5'b10010, 4'd1}) begin
            failures++;
            $display("FAIL reset_release got=%b want=%b", observed(), {5'b10010, 4'd1});
        end
        iniciar  = 1'b0;
        cancelar = 1'b1;
        @(negedge clock);
        cancelar = 1'b0;
        checks++;
        if (observed() !== 9'd0) begin
            failures++;
            $display("FAIL cancel_prepara got=%b want=%b", observed(), 9'd0);
        end
    endtask

    task automatic test_limit0();
        flag_tie = 1'b1;
        play("limit0", 1, 0, 0, 1);
        flag_tie = 1'b0;
    endtask

    task automatic test_limit3();
        play("limit3", 4, 0, 0, 1);
    endtask

    task automatic test_cancel();
        play("cancel_aceso2", 4, 2 + PER_ITEM + 1, 0, 1);
        play("rerun_after_cancel", 4, 0, 0, 1);
        play("cancel_at_terminal", 4, 2 + TA + TP - 1, 0, 1);
    endtask

    task automatic test_ignore_iniciar();
        play("iniciar_in_apagado", 4, 0, 2 + TA, 1);
    endtask

    task automatic test_back_to_back();
        play("held_iniciar", 2, 0, 0, 2);
    endtask

    task automatic test_random();
        int n, cc;
        for (int k = 0; k < 8; k++) begin
            n  = int'($urandom_range(1, 5));
            cc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, PER_ITEM * n + 1)) : 0;
            repeat ($urandom_range(0, 3)) @(negedge clock);
            play("random", n, cc, 0, 1);
        end
    endtask

    task automatic test_async_reset();
        limite = 8'd3;
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (mostra_leds !== 1'b1) begin
            failures++;
            $display("FAIL async_pre_leds got=%b want=1", mostra_leds);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (observed() !== 9'd0) begin
            failures++;
            $display("FAIL async_reset_drop got=%b want=%b", observed(), 9'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (observed() !== 9'd0) begin
                failures++;
                $display("FAIL async_reset_idle got=%b want=%b", observed(), 9'd0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_limit0();
        test_limit3();
        test_cancel();
        test_ignore_iniciar();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
